// File: rtl/mips_run_ctrl_pkg.sv
// Shared types and constants for the MIPS run/step/halt sequencer.
// Command, state and halt-reason encodings match the debug host protocol.
package mips_run_ctrl_pkg;

    localparam int         DATA_WIDTH  = 32;
    localparam logic [5:0] OPCODE_HALT = 6'b111111;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_STEP  = 2'd1,
        CMD_HALT  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        RC_IDLE  = 2'd0,
        RC_RUN   = 2'd1,
        RC_STEP  = 2'd2,
        RC_DRAIN = 2'd3
    } rc_state_e;

    typedef enum logic [1:0] {
        HR_NONE    = 2'd0,
        HR_CMD     = 2'd1,
        HR_HALT_OP = 2'd2,
        HR_STEP    = 2'd3
    } halt_reason_e;

    function automatic logic is_halt_op(input logic [5:0] opcode);
        return opcode == OPCODE_HALT;
    endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Debug-host command handshake: a command transfers on the clock edge
// where cmd_valid and cmd_ready are both high.
interface mips_run_ctrl_if;
    import mips_run_ctrl_pkg::*;

    logic    cmd_valid;
    cmd_op_e cmd_op;
    logic    cmd_ready;

    modport master (output cmd_valid, output cmd_op, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, output cmd_ready);

endinterface

// File: rtl/mips_perf_counter.sv
// Wrapping performance counter with synchronous clear and count enable.
// Clear takes priority over an increment in the same cycle.
module mips_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage MIPS pipeline: drives pipe_en,
// pc_hold and fetch_nop, drains the pipe before reporting halted.
module mips_run_ctrl
    import mips_run_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_run_ctrl_if.slave        cmd,
    input  logic [DATA_WIDTH-1:0] i_if_instr,
    input  logic                  i_wb_valid,
    output logic                  o_pipe_en,
    output logic                  o_pc_hold,
    output logic                  o_fetch_nop,
    output logic                  o_halted,
    output halt_reason_e          o_halt_reason,
    output logic [CNT_W-1:0]      o_cycle_count,
    output logic [CNT_W-1:0]      o_instr_count
);

    localparam int                DRAIN_W    = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

    rc_state_e          r_state;
    rc_state_e          w_state_next;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_next;
    logic               r_halted;
    logic               w_halted_next;
    halt_reason_e       r_halt_reason;
    halt_reason_e       w_reason_next;

    logic w_cmd_ready;
    logic w_accept;
    logic w_halt_op;
    logic w_clear;
    logic w_pipe_en;
    logic w_pc_hold;
    logic w_fetch_nop;

    // Only the opcode field matters here; the rest of the word is ignored.
    logic w_unused_instr_bits;
    assign w_unused_instr_bits = ^i_if_instr[25:0];

    assign w_halt_op   = is_halt_op(i_if_instr[31:26]);
    assign w_cmd_ready = (r_state == RC_IDLE) || (r_state == RC_RUN);
    assign w_accept    = cmd.cmd_valid && w_cmd_ready;
    assign w_clear     = w_accept && (cmd.cmd_op == CMD_CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RC_IDLE;
            r_drain_cnt   <= '0;
            r_halted      <= 1'b0;
            r_halt_reason <= HR_NONE;
        end else begin
            r_state       <= w_state_next;
            r_drain_cnt   <= w_drain_next;
            r_halted      <= w_halted_next;
            r_halt_reason <= w_reason_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_drain_next  = r_drain_cnt;
        w_halted_next = r_halted;
        w_reason_next = r_halt_reason;
        w_pipe_en     = 1'b0;
        w_pc_hold     = 1'b1;
        w_fetch_nop   = 1'b0;

        case (r_state)
            RC_IDLE: begin
                if (w_accept && (cmd.cmd_op == CMD_RUN)) begin
                    w_state_next  = RC_RUN;
                    w_halted_next = 1'b0;
                    w_reason_next = HR_NONE;
                end else if (w_accept && (cmd.cmd_op == CMD_STEP)) begin
                    w_state_next  = RC_STEP;
                    w_halted_next = 1'b0;
                    w_reason_next = HR_NONE;
                end
            end

            RC_RUN: begin
                // A HALT opcode never enters ID as a real instruction.
                w_pipe_en   = 1'b1;
                w_pc_hold   = w_halt_op;
                w_fetch_nop = w_halt_op;
                if (w_halt_op) begin
                    w_state_next  = RC_DRAIN;
                    w_drain_next  = DRAIN_LOAD;
                    w_reason_next = HR_HALT_OP;
                end else if (w_accept && (cmd.cmd_op == CMD_HALT)) begin
                    w_state_next  = RC_DRAIN;
                    w_drain_next  = DRAIN_LOAD;
                    w_reason_next = HR_CMD;
                end
            end

            RC_STEP: begin
                w_pipe_en     = 1'b1;
                w_pc_hold     = w_halt_op;
                w_fetch_nop   = w_halt_op;
                w_state_next  = RC_DRAIN;
                w_drain_next  = DRAIN_LOAD;
                w_reason_next = w_halt_op ? HR_HALT_OP : HR_STEP;
            end

            RC_DRAIN: begin
                w_pipe_en   = 1'b1;
                w_fetch_nop = 1'b1;
                if (r_drain_cnt <= DRAIN_W'(1)) begin
                    w_state_next  = RC_IDLE;
                    w_drain_next  = '0;
                    w_halted_next = 1'b1;
                end else begin
                    w_drain_next = r_drain_cnt - DRAIN_W'(1);
                end
            end

            default: begin
                w_state_next = RC_IDLE;
            end
        endcase
    end

    // Index 0 counts enabled cycles, index 1 counts retired instructions.
    logic [1:0]       w_cnt_en;
    logic [CNT_W-1:0] w_count [2];

    assign w_cnt_en[0] = w_pipe_en;
    assign w_cnt_en[1] = w_pipe_en && i_wb_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            mips_perf_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .reset   (reset),
                .i_clear (w_clear),
                .i_en    (w_cnt_en[gi]),
                .o_count (w_count[gi])
            );
        end
    endgenerate

    assign cmd.cmd_ready  = w_cmd_ready;
    assign o_pipe_en      = w_pipe_en;
    assign o_pc_hold      = w_pc_hold;
    assign o_fetch_nop    = w_fetch_nop;
    assign o_halted       = r_halted;
    assign o_halt_reason  = r_halt_reason;
    assign o_cycle_count  = w_count[0];
    assign o_instr_count  = w_count[1];

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl; a tiny pipeline model supplies
// if_instr and wb_valid from a program array.
module tb_mips_run_ctrl;
    import mips_run_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] if_instr;
    logic        wb_valid;
    logic        pipe_en, pc_hold, fetch_nop, halted;
    logic [1:0]  halt_reason;
    logic [31:0] cycle_count, instr_count;

    mips_run_ctrl_if cmd_if();

    mips_run_ctrl #(
        .PIPE_DEPTH (5),
        .CNT_W      (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd           (cmd_if),
        .i_if_instr    (if_instr),
        .i_wb_valid    (wb_valid),
        .o_pipe_en     (pipe_en),
        .o_pc_hold     (pc_hold),
        .o_fetch_nop   (fetch_nop),
        .o_halted      (halted),
        .o_halt_reason (halt_reason),
        .o_cycle_count (cycle_count),
        .o_instr_count (instr_count)
    );

    // Pipeline model: pv[0]=ID .. pv[3]=WB valid flags, word-indexed PC.
    logic [31:0] prog [64];
    logic [5:0]  pc;
    logic [3:0]  pv;
    logic        halt_in_id;
    int          accept_count = 0;

    assign if_instr = prog[pc];
    assign wb_valid = pv[3];

    always @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            pv         <= '0;
            halt_in_id <= 1'b0;
        end else if (pipe_en) begin
            if (!pc_hold) pc <= pc + 6'd1;
            pv <= {pv[2:0], ~fetch_nop};
            if (!fetch_nop && if_instr[31:26] == 6'h3F) halt_in_id <= 1'b1;
        end
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) accept_count <= accept_count + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int halt_at);
        for (int i = 0; i < 64; i++) begin
            prog[i] = {6'h08, 5'd0, 5'((i % 31) + 1), 16'(i)};
            if (i == halt_at) prog[i] = 32'hFC00_0000;
        end
    endtask

    task automatic do_reset();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = CMD_RUN;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        load_prog(-1);
        do_reset();
        n_checks++;
        if ({pipe_en, pc_hold, fetch_nop, cmd_if.cmd_ready} !== 4'b0101) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 0101", {pipe_en, pc_hold, fetch_nop, cmd_if.cmd_ready});
        end
        n_checks++;
        if (halted !== 1'b0 || halt_reason !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_status: got halted=%b reason=%0d expected 0/0", halted, halt_reason);
        end
        n_checks++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
        end
        $display("test_reset: outputs idle after reset");
    endtask

    task automatic test_halt_op();
        int n;
        load_prog(4);
        do_reset();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_RUN;
        tick();
        cmd_if.cmd_valid = 1'b0;
        n = 1;
        n_checks++;
        if (pipe_en !== 1'b1 || fetch_nop !== 1'b0 || pc_hold !== 1'b0) begin
            n_errors++;
            $display("FAIL run_entry: got pipe_en=%b fetch_nop=%b pc_hold=%b expected 1/0/0", pipe_en, fetch_nop, pc_hold);
        end
        while (halted !== 1'b1 && n < 40) begin
            if (n == 5) begin
                n_checks++;
                if (fetch_nop !== 1'b1 || pc_hold !== 1'b1) begin
                    n_errors++;
                    $display("FAIL halt_op_mealy: got fetch_nop=%b pc_hold=%b expected 1/1", fetch_nop, pc_hold);
                end
                // HALT command in the same cycle as the opcode
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_op    = CMD_HALT;
            end
            if (n == 6) begin
                cmd_if.cmd_valid = 1'b0;
                n_checks++;
                if (cmd_if.cmd_ready !== 1'b0 || fetch_nop !== 1'b1) begin
                    n_errors++;
                    $display("FAIL halt_op_drain: got cmd_ready=%b fetch_nop=%b expected 0/1", cmd_if.cmd_ready, fetch_nop);
                end
            end
            tick();
            n++;
        end
        n_checks++;
        if (n !== 10) begin
            n_errors++;
            $display("FAIL halt_op_latency: got %0d expected 10", n);
        end
        n_checks++;
        if (halt_reason !== 2'd2) begin
            n_errors++;
            $display("FAIL halt_op_reason: got %0d expected 2", halt_reason);
        end
        n_checks++;
        if (instr_count !== 32'd4 || cycle_count !== 32'd9) begin
            n_errors++;
            $display("FAIL halt_op_counts: got instr=%0d cycles=%0d expected 4/9", instr_count, cycle_count);
        end
        n_checks++;
        if (halt_in_id !== 1'b0 || pc !== 6'd4 || pipe_en !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_op_quiesce: got halt_in_id=%b pc=%0d pipe_en=%b expected 0/4/0", halt_in_id, pc, pipe_en);
        end
        $display("test_halt_op: halted after %0d cycles reason=%0d instr=%0d", n, halt_reason, instr_count);
    endtask

    task automatic test_halt_cmd();
        int n;
        load_prog(-1);
        do_reset();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_RUN;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_HALT;
        tick();
        cmd_if.cmd_valid = 1'b0;
        n = 1;
        while (halted !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 5) begin
            n_errors++;
            $display("FAIL halt_cmd_latency: got %0d expected 5", n);
        end
        n_checks++;
        if (halt_reason !== 2'd1) begin
            n_errors++;
            $display("FAIL halt_cmd_reason: got %0d expected 1", halt_reason);
        end
        n_checks++;
        if (instr_count !== 32'd10 || cycle_count !== 32'd14 || pc !== 6'd10) begin
            n_errors++;
            $display("FAIL halt_cmd_counts: got instr=%0d cycles=%0d pc=%0d expected 10/14/10", instr_count, cycle_count, pc);
        end
        $display("test_halt_cmd: halted %0d cycles after accept instr=%0d", n, instr_count);
    endtask

    task automatic test_back_to_back_step();
        int n;
        int acc0;
        load_prog(-1);
        do_reset();
        acc0 = accept_count;
        // STEP held continuously: only accepted once back in IDLE
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_STEP;
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while ((accept_count - acc0) < k && n < 20) begin
                tick();
                n++;
            end
            if (k == 3) cmd_if.cmd_valid = 1'b0;
            n_checks++;
            if (n !== 1) begin
                n_errors++;
                $display("FAIL step_accept_%0d: got %0d cycles expected 1", k, n);
            end
            n_checks++;
            if ({pipe_en, cmd_if.cmd_ready, pc_hold, fetch_nop, halted} !== 5'b10000 || halt_reason !== 2'd0) begin
                n_errors++;
                $display("FAIL step_state_%0d: got %b reason=%0d expected 10000 reason=0",
                         k, {pipe_en, cmd_if.cmd_ready, pc_hold, fetch_nop, halted}, halt_reason);
            end
            n = 1;
            while (halted !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            n_checks++;
            if (n !== 6 || (accept_count - acc0) !== k) begin
                n_errors++;
                $display("FAIL step_drain_%0d: got n=%0d accepts=%0d expected 6/%0d", k, n, accept_count - acc0, k);
            end
            n_checks++;
            if (pc !== 6'(k) || instr_count !== 32'(k) || halt_reason !== 2'd3) begin
                n_errors++;
                $display("FAIL step_result_%0d: got pc=%0d instr=%0d reason=%0d expected %0d/%0d/3",
                         k, pc, instr_count, halt_reason, k, k);
            end
            $display("test_step: step %0d pc=%0d instr=%0d cycles=%0d", k, pc, instr_count, cycle_count);
        end
        n_checks++;
        if (cycle_count !== 32'd15) begin
            n_errors++;
            $display("FAIL step_cycles: got %0d expected 15", cycle_count);
        end
    endtask

    task automatic test_clear();
        int n;
        load_prog(-1);
        do_reset();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_RUN;
        tick();
        cmd_if.cmd_valid = 1'b0;
        n = 1;
        while (wb_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 5 || cycle_count !== 32'd4 || instr_count !== 32'd0) begin
            n_errors++;
            $display("FAIL clear_pre: got n=%0d cycles=%0d instr=%0d expected 5/4/0", n, cycle_count, instr_count);
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_CLEAR;
        tick();
        cmd_if.cmd_valid = 1'b0;
        n_checks++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0 || pipe_en !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_wins: got cycles=%0d instr=%0d pipe_en=%b expected 0/0/1", cycle_count, instr_count, pipe_en);
        end
        tick();
        n_checks++;
        if (cycle_count !== 32'd1 || instr_count !== 32'd1) begin
            n_errors++;
            $display("FAIL clear_resume1: got %0d/%0d expected 1/1", cycle_count, instr_count);
        end
        tick();
        n_checks++;
        if (cycle_count !== 32'd2 || instr_count !== 32'd2) begin
            n_errors++;
            $display("FAIL clear_resume2: got %0d/%0d expected 2/2", cycle_count, instr_count);
        end
        $display("test_clear: counters cleared then resumed at %0d/%0d", cycle_count, instr_count);
    endtask

    task automatic test_reset_mid_drain();
        int n;
        load_prog(-1);
        do_reset();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_RUN;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_HALT;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({pipe_en, pc_hold, fetch_nop, cmd_if.cmd_ready, halted} !== 5'b01010 || halt_reason !== 2'd0) begin
            n_errors++;
            $display("FAIL mid_drain_reset: got %b reason=%0d expected 01010 reason=0",
                     {pipe_en, pc_hold, fetch_nop, cmd_if.cmd_ready, halted}, halt_reason);
        end
        n_checks++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            n_errors++;
            $display("FAIL mid_drain_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_RUN;
        tick();
        cmd_if.cmd_valid = 1'b0;
        n_checks++;
        if (pipe_en !== 1'b1 || cycle_count !== 32'd0) begin
            n_errors++;
            $display("FAIL restart_run: got pipe_en=%b cycles=%0d expected 1/0", pipe_en, cycle_count);
        end
        tick();
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_HALT;
        tick();
        cmd_if.cmd_valid = 1'b0;
        n = 1;
        while (halted !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 5 || halt_reason !== 2'd1 || instr_count !== 32'd3 || cycle_count !== 32'd7) begin
            n_errors++;
            $display("FAIL restart_halt: got n=%0d reason=%0d instr=%0d cycles=%0d expected 5/1/3/7",
                     n, halt_reason, instr_count, cycle_count);
        end
        $display("test_reset_mid_drain: restarted and halted after %0d cycles", n);
    endtask

    task automatic test_drain_cmds();
        int acc0;
        cmd_op_e ops [4];
        ops = '{CMD_STEP, CMD_HALT, CMD_RUN, CMD_STEP};
        load_prog(-1);
        do_reset();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_RUN;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = CMD_HALT;
        tick();
        acc0 = accept_count;
        for (int i = 0; i < 4; i++) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_op    = ops[i];
            n_checks++;
            if ({cmd_if.cmd_ready, pipe_en, fetch_nop, pc_hold, halted} !== 5'b01110) begin
                n_errors++;
                $display("FAIL drain_cmd_%0d: got %b expected 01110", i, {cmd_if.cmd_ready, pipe_en, fetch_nop, pc_hold, halted});
            end
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || pipe_en !== 1'b0 || accept_count !== acc0 || halt_reason !== 2'd1) begin
            n_errors++;
            $display("FAIL drain_cmd_end: got halted=%b pipe_en=%b accepts=%0d reason=%0d expected 1/0/%0d/1",
                     halted, pipe_en, accept_count - acc0, halt_reason, 0);
        end
        n_checks++;
        if (instr_count !== 32'd2 || cycle_count !== 32'd6) begin
            n_errors++;
            $display("FAIL drain_cmd_counts: got %0d/%0d expected 2/6", instr_count, cycle_count);
        end
        $display("test_drain_cmds: drain commands ignored, halted reason=%0d", halt_reason);
    endtask

    initial begin
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = CMD_RUN;
        test_reset();
        test_halt_op();
        test_halt_cmd();
        test_back_to_back_step();
        test_clear();
        test_reset_mid_drain();
        test_drain_cmds();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
